// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: converts a 14-bit binary result to BCD with a sequential
// double-dabble engine and scans the four digits onto an active-low,
// common-switched seven-segment display with leading-zero blanking.
module fnd_scan_ctrl #(
    parameter int TICK_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic        ovf,
    output logic        pls_tick,
    output logic [3:0]  fnd_com,
    output logic [6:0]  fnd_data
);

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Active-low {g,f,e,d,c,b,a} pattern; blank and out-of-range codes are dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit, input logic blank);
        logic [6:0] seg;
        if (blank) begin
            seg = 7'h7F;
        end else begin
            case (digit)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'h7F;
            endcase
        end
        return seg;
    endfunction

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic             pls_tick_r;
    logic [1:0]       sel_r;
    state_t           state_r;
    logic [13:0]      bin_r;
    logic [15:0]      bcd_r;
    logic [3:0]       iter_r;
    logic             ovf_r;
    logic             busy_r;
    logic [15:0]      digits_r;
    logic [3:0]       fnd_com_r;
    logic [6:0]       fnd_data_r;

    logic [1:0]       sel_next_s;
    logic [15:0]      digits_next_s;
    logic [15:0]      bcd_adj_s;
    logic [15:0]      bcd_shift_s;
    logic [13:0]      bin_shift_s;
    logic [13:0]      clamp_s;
    logic [3:0]       blank_s;
    logic [3:0]       digit_cur_s;
    logic [3:0]       com_next_s;
    logic [6:0]       data_next_s;

    // Next-cycle scan index and digits, so the registered outputs track them without lag.
    always_comb begin
        sel_next_s    = 2'd0;
        digits_next_s = 16'd0;
        if (pls_tick_r) begin
            sel_next_s = sel_r + 2'd1;
        end else begin
            sel_next_s = sel_r;
        end
        if (state_r == ST_COMMIT) begin
            digits_next_s = bcd_r;
        end else begin
            digits_next_s = digits_r;
        end
    end

    // One double-dabble step plus input clamping to the displayable range.
    always_comb begin
        bcd_adj_s   = {dabble_adj(bcd_r[15:12]), dabble_adj(bcd_r[11:8]),
                       dabble_adj(bcd_r[7:4]),   dabble_adj(bcd_r[3:0])};
        bcd_shift_s = (bcd_adj_s << 4'd1) | {15'd0, bin_r[13]};
        bin_shift_s = bin_r << 4'd1;
        if (value > 14'd9999) begin
            clamp_s = 14'd9999;
        end else begin
            clamp_s = value;
        end
    end

    // Leading-zero blanking and segment/common selection for the upcoming slot.
    always_comb begin
        blank_s[3] = (digits_next_s[15:12] == 4'd0);
        blank_s[2] = blank_s[3] && (digits_next_s[11:8] == 4'd0);
        blank_s[1] = blank_s[2] && (digits_next_s[7:4] == 4'd0);
        blank_s[0] = 1'b0;
        case (sel_next_s)
            2'd0:    digit_cur_s = digits_next_s[3:0];
            2'd1:    digit_cur_s = digits_next_s[7:4];
            2'd2:    digit_cur_s = digits_next_s[11:8];
            2'd3:    digit_cur_s = digits_next_s[15:12];
            default: digit_cur_s = 4'd0;
        endcase
        com_next_s  = ~(4'b0001 << sel_next_s);
        data_next_s = seg_decode(digit_cur_s, blank_s[sel_next_s]);
    end

    // Slot timer, tick pulse (high while cnt is at its last value) and scan index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= CNT_ZERO;
            pls_tick_r <= 1'b0;
            sel_r      <= 2'd0;
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            pls_tick_r <= (cnt_r == CNT_PRE);
            sel_r      <= sel_next_s;
        end
    end

    // Conversion FSM: capture, 14 shift steps, then commit to the display digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            bin_r    <= 14'd0;
            bcd_r    <= 16'd0;
            iter_r   <= 4'd0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            digits_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        bin_r   <= clamp_s;
                        bcd_r   <= 16'd0;
                        ovf_r   <= (value > 14'd9999);
                        iter_r  <= 4'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    bin_r  <= bin_shift_s;
                    bcd_r  <= bcd_shift_s;
                    iter_r <= iter_r + 4'd1;
                    if (iter_r == 4'd13) begin
                        state_r <= ST_COMMIT;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_COMMIT: begin
                    digits_r <= bcd_r;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered display drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fnd_com_r  <= 4'b1110;
            fnd_data_r <= 7'b1000000;
        end else begin
            fnd_com_r  <= com_next_s;
            fnd_data_r <= data_next_s;
        end
    end

    assign busy     = busy_r;
    assign ovf      = ovf_r;
    assign pls_tick = pls_tick_r;
    assign fnd_com  = fnd_com_r;
    assign fnd_data = fnd_data_r;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with a 4-cycle digit slot.
module tb_fnd_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic        ovf;
    logic        pls_tick;
    logic [3:0]  fnd_com;
    logic [6:0]  fnd_data;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    fnd_scan_ctrl #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .ovf      (ovf),
        .pls_tick (pls_tick),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse load for one sampled edge, then count busy cycles (bounded).
    task automatic do_load(input logic [13:0] v, input int inject_at,
                           input logic [13:0] v2, output int busy_cycles);
        int cnt;
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == inject_at) begin
                value = v2;
                load  = 1'b1;
            end else begin
                load  = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        busy_cycles = cnt;
    endtask

    // Align to digit 0 then check each of the four slots.
    task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] exp_seg [4];
        int w;
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
        w = 0;
        while (fnd_com !== 4'b1110 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_align"}, {15'd0, fnd_com === 4'b1110}, 16'd1);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] ec;
            ec = ~(4'b0001 << k);
            check($sformatf("%s_com%0d", tag, k), {12'd0, fnd_com}, {12'd0, ec});
            check($sformatf("%s_seg%0d", tag, k), {9'd0, fnd_data}, {9'd0, exp_seg[k]});
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        int bc;
        rst   = 1'b1;
        value = 14'd0;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_ovf", {15'd0, ovf}, 16'd0);
        check("rst_tick", {15'd0, pls_tick}, 16'd0);
        check("rst_com", {12'd0, fnd_com}, 16'b1110);
        check("rst_seg", {9'd0, fnd_data}, {9'd0, SEG_0});
        rst = 1'b0;

        // Free-running scan from reset release: 4 samples per slot.
        for (int k = 0; k < 17; k++) begin
            logic [1:0] idx;
            logic [3:0] ec;
            logic [6:0] es;
            idx = 2'((k / 4) % 4);
            ec  = ~(4'b0001 << idx);
            es  = (idx == 2'd0) ? SEG_0 : SEG_BLANK;
            check($sformatf("scan_com_k%0d", k), {12'd0, fnd_com}, {12'd0, ec});
            check($sformatf("scan_seg_k%0d", k), {9'd0, fnd_data}, {9'd0, es});
            check($sformatf("scan_tick_k%0d", k), {15'd0, pls_tick}, {15'd0, (k % 4) == 3});
            @(negedge clk);
        end

        do_load(14'd1234, 0, 14'd0, bc);
        check("l1234_busy", 16'(bc), 16'd15);
        check("l1234_ovf", {15'd0, ovf}, 16'd0);
        scan_check("l1234", SEG_4, SEG_3, SEG_2, SEG_1);

        do_load(14'd7, 0, 14'd0, bc);
        check("l7_busy", 16'(bc), 16'd15);
        scan_check("l7", SEG_7, SEG_BLANK, SEG_BLANK, SEG_BLANK);

        do_load(14'd1005, 0, 14'd0, bc);
        scan_check("l1005", SEG_5, SEG_0, SEG_0, SEG_1);

        value = 14'd16383;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        check("l16383_ovf_early", {15'd0, ovf}, 16'd1);
        check("l16383_busy_early", {15'd0, busy}, 16'd1);
        repeat (20) @(negedge clk);
        check("l16383_ovf", {15'd0, ovf}, 16'd1);
        scan_check("l16383", SEG_9, SEG_9, SEG_9, SEG_9);

        do_load(14'd42, 0, 14'd0, bc);
        check("l42_ovf", {15'd0, ovf}, 16'd0);
        scan_check("l42", SEG_2, SEG_4, SEG_BLANK, SEG_BLANK);

        do_load(14'd1234, 3, 14'd5678, bc);
        check("ign_busy", 16'(bc), 16'd15);
        repeat (3) @(negedge clk);
        check("ign_idle", {15'd0, busy}, 16'd0);
        scan_check("ign", SEG_4, SEG_3, SEG_2, SEG_1);

        value = 14'd9999;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", {15'd0, busy}, 16'd0);
        check("arst_ovf", {15'd0, ovf}, 16'd0);
        check("arst_tick", {15'd0, pls_tick}, 16'd0);
        check("arst_com", {12'd0, fnd_com}, 16'b1110);
        check("arst_seg", {9'd0, fnd_data}, {9'd0, SEG_0});
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_busy", {15'd0, busy}, 16'd0);
        scan_check("post", SEG_0, SEG_BLANK, SEG_BLANK, SEG_BLANK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
